// File: rtl/loteria_pkg.sv
// Shared types and constants for the Loteria input front-end.
package loteria_pkg;

  localparam int unsigned N_DIGITOS_DEF = 4;
  localparam int unsigned NUM_MAX_DEF   = 9;
  localparam int unsigned DIGITO_W      = 4;

  // Button indices; the COLETA priority runs fim > apagar > insere > confirma > fim_jogo
  localparam int unsigned N_BOTOES     = 5;
  localparam int unsigned BTN_INSERE   = 0;
  localparam int unsigned BTN_APAGAR   = 1;
  localparam int unsigned BTN_CONFIRMA = 2;
  localparam int unsigned BTN_FIM_JOGO = 3;
  localparam int unsigned BTN_FIM      = 4;

  typedef enum logic [1:0] {
    COLETA = 2'd0,
    ENVIA  = 2'd1,
    ESPERA = 2'd2,
    FINAL  = 2'd3
  } estado_t;

endpackage

// File: rtl/loteria_botao.sv
// Button conditioning: 2-FF synchroniser, stability debounce and registered rising-edge pulse.
module loteria_botao #(
  parameter int unsigned DEBOUNCE_CICLOS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulso
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] ALVO = CW'(DEBOUNCE_CICLOS);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_nivel;
  logic          r_nivel_q;
  logic          r_pulso;
  logic [CW-1:0] r_cnt;

  // Level flips only after DEBOUNCE_CICLOS consecutive samples disagree with it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_nivel   <= 1'b0;
      r_nivel_q <= 1'b0;
      r_pulso   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_nivel_q <= r_nivel;
      r_pulso   <= r_nivel & ~r_nivel_q;
      if (r_sync2 != r_nivel) begin
        if (r_cnt == ALVO - CW'(1)) begin
          r_nivel <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_pulso = r_pulso;

endmodule

// File: rtl/loteria_entrada.sv
// Loteria front-end: collects a bet from the switches, replays it as an insere burst, drives fim_jogo/fim.
module loteria_entrada
  import loteria_pkg::*;
#(
  parameter int unsigned N_DIGITOS       = N_DIGITOS_DEF,
  parameter int unsigned DEBOUNCE_CICLOS = 4,
  parameter int unsigned NUM_MAX         = NUM_MAX_DEF
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [DIGITO_W-1:0]                sw_numero,
  input  logic                               btn_insere,
  input  logic                               btn_apagar,
  input  logic                               btn_confirma,
  input  logic                               btn_fim_jogo,
  input  logic                               btn_fim,
  output logic [DIGITO_W-1:0]                numero,
  output logic                               insere,
  output logic                               fim_jogo,
  output logic                               fim,
  output logic [$clog2(N_DIGITOS+1)-1:0]     contagem,
  output logic                               erro,
  output logic                               ocupado
);

  localparam int unsigned CW = $clog2(N_DIGITOS + 1);
  localparam int unsigned IW = $clog2(N_DIGITOS);
  localparam logic [CW-1:0]       CHEIO  = CW'(N_DIGITOS);
  localparam logic [IW-1:0]       ULTIMO = IW'(N_DIGITOS - 1);
  localparam logic [DIGITO_W-1:0] MAXD   = DIGITO_W'(NUM_MAX);

  logic [N_BOTOES-1:0] w_btn_raw;
  logic [N_BOTOES-1:0] w_pulso;

  assign w_btn_raw = {btn_fim, btn_fim_jogo, btn_confirma, btn_apagar, btn_insere};

  for (genvar g = 0; g < N_BOTOES; g++) begin : g_botao
    loteria_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_botao (
      .clock   (clock),
      .reset   (reset),
      .i_btn   (w_btn_raw[g]),
      .o_pulso (w_pulso[g])
    );
  end

  estado_t             r_estado;
  logic [DIGITO_W-1:0] r_buf [N_DIGITOS];
  logic [CW-1:0]       r_contagem;
  logic [IW-1:0]       r_idx;
  logic [DIGITO_W-1:0] r_numero;
  logic                r_insere;
  logic                r_fim_jogo;
  logic                r_fim;
  logic                r_erro;
  logic                r_ocupado;

  estado_t             w_estado_nx;
  logic [CW-1:0]       w_contagem_nx;
  logic [IW-1:0]       w_idx_nx;
  logic [DIGITO_W-1:0] w_numero_nx;
  logic                w_insere_nx;
  logic                w_fim_jogo_nx;
  logic                w_fim_nx;
  logic                w_erro_nx;
  logic                w_ocupado_nx;
  logic                w_wr_en;

  always_comb begin
    w_estado_nx   = r_estado;
    w_contagem_nx = r_contagem;
    w_idx_nx      = r_idx;
    w_numero_nx   = '0;
    w_insere_nx   = 1'b0;
    w_fim_jogo_nx = 1'b0;
    w_fim_nx      = r_fim;
    w_erro_nx     = 1'b0;
    w_wr_en       = 1'b0;
    case (r_estado)
      COLETA: begin
        if (w_pulso[BTN_FIM]) begin
          w_fim_nx    = 1'b1;
          w_estado_nx = FINAL;
        end else if (w_pulso[BTN_APAGAR]) begin
          if (r_contagem != '0) w_contagem_nx = r_contagem - CW'(1);
        end else if (w_pulso[BTN_INSERE]) begin
          if ((sw_numero <= MAXD) && (r_contagem < CHEIO)) begin
            w_wr_en       = 1'b1;
            w_contagem_nx = r_contagem + CW'(1);
          end else begin
            w_erro_nx = 1'b1;
          end
        end else if (w_pulso[BTN_CONFIRMA]) begin
          if (r_contagem == CHEIO) begin
            w_estado_nx = ENVIA;
            w_insere_nx = 1'b1;
            w_numero_nx = r_buf[0];
            w_idx_nx    = '0;
          end else begin
            w_erro_nx = 1'b1;
          end
        end else if (w_pulso[BTN_FIM_JOGO]) begin
          w_erro_nx = 1'b1;
        end
      end
      // Burst replay; button pulses are dropped here by design
      ENVIA: begin
        if (r_idx == ULTIMO) begin
          w_contagem_nx = '0;
          w_idx_nx      = '0;
          w_estado_nx   = ESPERA;
        end else begin
          w_idx_nx    = r_idx + IW'(1);
          w_insere_nx = 1'b1;
          w_numero_nx = r_buf[w_idx_nx];
        end
      end
      ESPERA: begin
        if (w_pulso[BTN_FIM]) begin
          w_fim_nx    = 1'b1;
          w_estado_nx = FINAL;
        end else if (w_pulso[BTN_APAGAR]) begin
          w_erro_nx = 1'b0;
        end else if (w_pulso[BTN_INSERE] || w_pulso[BTN_CONFIRMA]) begin
          w_erro_nx = 1'b1;
        end else if (w_pulso[BTN_FIM_JOGO]) begin
          w_fim_jogo_nx = 1'b1;
          w_estado_nx   = COLETA;
        end
      end
      FINAL: begin
        w_fim_nx = 1'b1;
      end
      default: begin
        w_estado_nx = COLETA;
      end
    endcase
    w_ocupado_nx = (w_estado_nx == ENVIA) || (w_estado_nx == FINAL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= COLETA;
      r_contagem <= '0;
      r_idx      <= '0;
      r_numero   <= '0;
      r_insere   <= 1'b0;
      r_fim_jogo <= 1'b0;
      r_fim      <= 1'b0;
      r_erro     <= 1'b0;
      r_ocupado  <= 1'b0;
      for (int i = 0; i < N_DIGITOS; i++) r_buf[i] <= '0;
    end else begin
      r_estado   <= w_estado_nx;
      r_contagem <= w_contagem_nx;
      r_idx      <= w_idx_nx;
      r_numero   <= w_numero_nx;
      r_insere   <= w_insere_nx;
      r_fim_jogo <= w_fim_jogo_nx;
      r_fim      <= w_fim_nx;
      r_erro     <= w_erro_nx;
      r_ocupado  <= w_ocupado_nx;
      if (w_wr_en) r_buf[IW'(r_contagem)] <= sw_numero;
    end
  end

  assign numero   = r_numero;
  assign insere   = r_insere;
  assign fim_jogo = r_fim_jogo;
  assign fim      = r_fim;
  assign contagem = r_contagem;
  assign erro     = r_erro;
  assign ocupado  = r_ocupado;

endmodule

// File: tb/tb_loteria_entrada.sv
// Scoreboard bench for loteria_entrada: a bet-level model queues expected strobes, a monitor consumes them.
module tb_loteria_entrada;

  localparam int N    = 4;
  localparam int D    = 2;
  localparam int NMAX = 9;

  localparam int B_INS = 0, B_APG = 1, B_CONF = 2, B_FJ = 3, B_FIM = 4;
  localparam int EV_INS = 0, EV_ERR = 1, EV_FJ = 2;

  logic       clock;
  logic       reset;
  logic [3:0] sw_numero;
  logic       btn_insere, btn_apagar, btn_confirma, btn_fim_jogo, btn_fim;
  logic [3:0] numero;
  logic       insere, fim_jogo, fim, erro, ocupado;
  logic [2:0] contagem;

  loteria_entrada #(.N_DIGITOS(N), .DEBOUNCE_CICLOS(D), .NUM_MAX(NMAX)) dut (
    .clock        (clock),
    .reset        (reset),
    .sw_numero    (sw_numero),
    .btn_insere   (btn_insere),
    .btn_apagar   (btn_apagar),
    .btn_confirma (btn_confirma),
    .btn_fim_jogo (btn_fim_jogo),
    .btn_fim      (btn_fim),
    .numero       (numero),
    .insere       (insere),
    .fim_jogo     (fim_jogo),
    .fim          (fim),
    .contagem     (contagem),
    .erro         (erro),
    .ocupado      (ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t sb[$];
  int  bet[$];
  bit  m_espera, m_final, m_fim;
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string nome, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Observed strobe must match the oldest pending expectation (kind*16+digit)
  task automatic pop_ev(input string nome, input int kind, input int val);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got unexpected strobe value %0d, expected none (t=%0t)", nome, val, $time);
    end else begin
      e = sb.pop_front();
      vectors--;
      check(nome, kind * 16 + val, e.kind * 16 + e.val);
    end
  endtask

  task automatic monitor_step();
    if (reset) begin
      if (!insere) check("numero_idle", int'(numero), 0);
      if (insere) begin
        pop_ev("insere_burst", EV_INS, int'(numero));
        check("ocupado_burst", int'(ocupado), 1);
      end
      if (erro) pop_ev("erro_pulse", EV_ERR, 0);
      if (fim_jogo) pop_ev("fim_jogo_pulse", EV_FJ, 0);
    end
  endtask

  task automatic model(input int b, input int sw);
    if (m_final) return;
    if (b == B_FIM) begin
      m_fim = 1'b1;
      m_final = 1'b1;
      return;
    end
    if (m_espera) begin
      if (b == B_INS || b == B_CONF) push_ev(EV_ERR, 0);
      else if (b == B_FJ) begin
        push_ev(EV_FJ, 0);
        m_espera = 1'b0;
      end
      return;
    end
    case (b)
      B_APG:  if (bet.size() > 0) void'(bet.pop_back());
      B_INS:  if (sw <= NMAX && bet.size() < N) bet.push_back(sw);
              else push_ev(EV_ERR, 0);
      B_CONF: if (bet.size() == N) begin
                foreach (bet[i]) push_ev(EV_INS, bet[i]);
                bet.delete();
                m_espera = 1'b1;
              end else push_ev(EV_ERR, 0);
      B_FJ:   push_ev(EV_ERR, 0);
      default: ;
    endcase
  endtask

  task automatic model_reset();
    bet.delete();
    sb.delete();
    m_espera = 1'b0;
    m_final  = 1'b0;
    m_fim    = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_btn(input int b, input logic v);
    case (b)
      B_INS:  btn_insere   = v;
      B_APG:  btn_apagar   = v;
      B_CONF: btn_confirma = v;
      B_FJ:   btn_fim_jogo = v;
      default: btn_fim     = v;
    endcase
  endtask

  task automatic check_levels(input string tag);
    check({tag, "_contagem"}, int'(contagem), bet.size());
    check({tag, "_fim"}, int'(fim), int'(m_fim));
    check({tag, "_ocupado"}, int'(ocupado), int'(m_final));
    check({tag, "_insere_idle"}, int'(insere), 0);
    check({tag, "_pending"}, sb.size(), 0);
  endtask

  task automatic press(input int b, input int sw, input int hold, input bit settle);
    sw_numero = 4'(sw);
    model(b, sw);
    drive_btn(b, 1'b1);
    tick((hold > 0) ? hold : int'($urandom_range(3, 8)));
    drive_btn(b, 1'b0);
    if (settle) tick(14);
  endtask

  initial begin
    int  b, sw, r;
    bit  found;
    reset = 1'b0;
    sw_numero = '0;
    btn_insere = 0; btn_apagar = 0; btn_confirma = 0; btn_fim_jogo = 0; btn_fim = 0;
    model_reset();
    fork
      forever begin
        @(negedge clock);
        monitor_step();
      end
    join_none

    tick(3);
    check("rst_numero", int'(numero), 0);
    check("rst_insere", int'(insere), 0);
    check("rst_fim_jogo", int'(fim_jogo), 0);
    check("rst_fim", int'(fim), 0);
    check("rst_contagem", int'(contagem), 0);
    check("rst_erro", int'(erro), 0);
    check("rst_ocupado", int'(ocupado), 0);
    reset = 1'b1;
    tick(2);

    // Basic bet 0,3,8,2 and game close
    press(B_INS, 0, 0, 1);
    press(B_INS, 3, 0, 1);
    press(B_INS, 8, 0, 1);
    press(B_INS, 2, 0, 1);
    check_levels("fill4");
    press(B_CONF, 0, 0, 1);
    check_levels("burst1");
    press(B_FJ, 0, 0, 1);
    check_levels("fimjogo1");

    // One-cycle glitch must be filtered, long press stores one digit
    sw_numero = 4'd5;
    btn_insere = 1'b1;
    tick(1);
    btn_insere = 1'b0;
    tick(10);
    check_levels("glitch");
    press(B_INS, 5, 10, 1);
    check_levels("long_press");

    // Full-buffer and out-of-range rejections
    press(B_INS, 1, 0, 1);
    press(B_INS, 4, 0, 1);
    press(B_INS, 6, 0, 1);
    press(B_INS, 7, 0, 1);
    check_levels("overfill");
    press(B_APG, 0, 0, 1);
    press(B_INS, 12, 0, 1);
    check_levels("out_of_range");
    press(B_INS, 9, 0, 1);
    press(B_CONF, 0, 0, 1);
    press(B_FJ, 0, 0, 1);
    check_levels("burst2");

    // Premature confirma and delete past empty
    press(B_INS, 2, 0, 1);
    press(B_INS, 7, 0, 1);
    press(B_CONF, 0, 0, 1);
    check_levels("early_conf");
    press(B_APG, 0, 0, 1);
    press(B_APG, 0, 0, 1);
    press(B_APG, 0, 0, 1);
    check_levels("empty_del");

    // Randomized traffic excluding fim
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 99);
      if (r < 50) b = B_INS;
      else if (r < 65) b = B_APG;
      else if (r < 85) b = B_CONF;
      else b = B_FJ;
      sw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15));
      press(b, sw, 0, 1);
      if (k % 10 == 9) check_levels("random");
    end

    // fim is sticky and FINAL ignores everything
    press(B_FIM, 0, 0, 1);
    check_levels("fim_set");
    press(B_INS, 3, 0, 1);
    press(B_CONF, 0, 0, 1);
    press(B_FJ, 0, 0, 1);
    press(B_FIM, 0, 0, 1);
    check_levels("final_ignore");

    // Reset during the second burst cycle aborts the replay
    reset = 1'b0;
    tick(2);
    model_reset();
    reset = 1'b1;
    tick(2);
    check_levels("after_reset");
    press(B_INS, 1, 0, 1);
    press(B_INS, 2, 0, 1);
    press(B_INS, 3, 0, 1);
    press(B_INS, 4, 0, 1);
    press(B_CONF, 0, 3, 0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (insere) begin
        found = 1'b1;
        break;
      end
    end
    check("burst_start_seen", int'(found), 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort_insere", int'(insere), 0);
    check("abort_numero", int'(numero), 0);
    check("abort_contagem", int'(contagem), 0);
    check("abort_ocupado", int'(ocupado), 0);
    model_reset();
    tick(3);
    reset = 1'b1;
    tick(30);
    check_levels("no_residual");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/loteria_entrada.md
Name: loteria_entrada

Overview:
Front-end stage that feeds the Loteria block. Conditions the raw player buttons (synchronise, debounce, edge-detect) and collects a bet of N_DIGITOS digits from the switches into a local buffer, with delete support. On confirmation it replays the buffered bet into Loteria as a burst of insere/numero cycles. It also generates Loteria's fim_jogo and fim controls.

Parameters:
N_DIGITOS, 4, digits per bet (2..7)
DEBOUNCE_CICLOS, 4, consecutive stable synchronised cycles required before a button level is accepted (1..255)
NUM_MAX, 9, largest valid digit; entries above it are rejected

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
sw_numero  in  4  digit switches, sampled when the insere press is accepted
btn_insere  in  1  raw button: push sw_numero into buffer
btn_apagar  in  1  raw button: delete last buffered digit
btn_confirma  in  1  raw button: send complete bet
btn_fim_jogo  in  1  raw button: close current game
btn_fim  in  1  raw button: end session
numero  out  4  digit to Loteria, valid while insere=1
insere  out  1  Loteria insert strobe, high for N_DIGITOS consecutive cycles per bet
fim_jogo  out  1  one-cycle pulse to Loteria
fim  out  1  level to Loteria, sticky until reset
contagem  out  $clog2(N_DIGITOS+1)  digits currently buffered
erro  out  1  one-cycle pulse on any rejected action
ocupado  out  1  high in ENVIA and FINAL

Behaviour:
- Reset (reset=0, async): all outputs 0, buffer count 0, state COLETA, debouncers cleared to released (0).
- Button path, per button: 2-FF synchroniser, then debounce counter. The debounced level changes after DEBOUNCE_CICLOS consecutive synced samples differ from the current level. A registered rising-edge pulse follows.
- Raw rise to internal pulse latency: 2+DEBOUNCE_CICLOS+1 clock edges. The pulse lasts exactly 1 cycle per press.
- FSM states: COLETA, ENVIA, ESPERA, FINAL.
- COLETA, priority when several pulses arrive in one cycle: fim > apagar > insere > confirma > fim_jogo. Only the highest-priority pulse acts; the rest are dropped without erro.
- COLETA, insere: if sw_numero<=NUM_MAX and contagem<N_DIGITOS, store at buf[contagem] and increment contagem. Otherwise erro, no change.
- COLETA, apagar: if contagem>0, decrement. If contagem==0, no-op with no erro.
- COLETA, confirma: if contagem==N_DIGITOS, go to ENVIA. Otherwise erro, stay in COLETA.
- COLETA, fim_jogo: erro (no bet sent yet).
- ENVIA: starting the cycle after confirma, insere=1 with numero=buf[i] for i=0..N_DIGITOS-1 on consecutive cycles, no gaps. Next cycle: insere=0, numero=0, contagem=0, go to ESPERA. All button pulses in ENVIA are discarded with no erro.
- ESPERA: fim_jogo pulse gives output fim_jogo=1 for exactly 1 cycle, then COLETA. insere and confirma give erro. apagar is ignored.
- fim pulse, in any state except ENVIA: fim=1 from the next cycle and held, go to FINAL. In ENVIA the fim pulse is discarded.
- FINAL: everything ignored, fim stays 1, ocupado=1. Leave only via reset.
- numero is 0 whenever insere=0.
- contagem width exactly holds N_DIGITOS; no wrap. Full and empty are guarded as above.
- Reset mid-ENVIA aborts the burst immediately: insere=0 asynchronously and the buffer is discarded.

Decomposition:
- Package loteria_pkg: FSM state enum (COLETA, ENVIA, ESPERA, FINAL), default N_DIGITOS/NUM_MAX constants, and the button index constants used for the priority order.
- Sub-module loteria_botao (parameter DEBOUNCE_CICLOS): synchroniser, debounce counter and rising-edge pulse. Instantiated 5 times.
- Top contains the buffer (N_DIGITOS x 4 regs), the replay index and the FSM.

Test Plan:
- DEBOUNCE_CICLOS=2. Release reset, press insere with sw 0,3,8,2, then confirma → from the cycle after the confirma pulse, insere=1 for 4 cycles with numero 0,3,8,2; then contagem=0, state ESPERA.
- Glitch of 1 cycle on btn_insere, then a 10-cycle press with sw=5 → exactly one digit stored, contagem=1, no erro.
- Insert 4 digits, insert a 5th (sw=7), then sw=12 after one apagar → erro pulse each time, contagem stays 4 then 3, buffer unchanged.
- Press confirma with contagem=2 → erro, no insere; then apagar three times → contagem 0, no erro on the third.
- After a burst, press fim_jogo → fim_jogo high exactly 1 cycle, back to COLETA. Then press fim → fim=1 sticky, ocupado=1, later presses ignored.
- Drive reset low on the 2nd insere cycle of a burst → insere, numero, contagem go to 0 before the next edge. After release, no residual burst occurs.
